// File: rtl/mutex_bram_bank.sv
// mutex_bram_bank: bank of C_BUFF_NUM block RAMs shared between one writer and
// C_RD_NUM readers. Buffer ownership rotates on start-of-frame pulses and a
// buffer is never owned by the writer and a reader at the same time.
// Reads have a fixed 3-cycle latency: request, RAM address register, RAM
// output register, output mux register.
// Optional feature: define MUTEX_BANK_CONFLICT_STAT_EN to add conflict_cnt.
module mutex_bram_bank #(
  parameter int C_BUFF_NUM = 4,
  parameter int C_RD_NUM   = 2,
  parameter int BR_AW      = 12,
  parameter int BR_DW      = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           w_sof,
  output logic [C_BUFF_NUM-1:0]          w_bmp,
  input  logic                           w_en,
  input  logic [BR_AW-1:0]               w_addr,
  input  logic [BR_DW-1:0]               w_data,
  input  logic                           w_ren,
  input  logic [BR_AW-1:0]               w_raddr,
  output logic [BR_DW-1:0]               w_rdata,
  output logic                           w_rvalid,
  input  logic [C_RD_NUM-1:0]            r_sof,
  output logic [C_BUFF_NUM*C_RD_NUM-1:0] r_bmp,
  input  logic [C_RD_NUM-1:0]            r_en,
  input  logic [BR_AW*C_RD_NUM-1:0]      r_addr,
  output logic [BR_DW*C_RD_NUM-1:0]      r_data,
  output logic [C_RD_NUM-1:0]            r_rvalid,
  output logic [C_RD_NUM-1:0]            r_conflict
`ifdef MUTEX_BANK_CONFLICT_STAT_EN
  ,
  output logic [15:0]                    conflict_cnt
`endif
);

  localparam int BN    = C_BUFF_NUM;
  localparam int RN    = C_RD_NUM;
  localparam int DEPTH = 1 << BR_AW;

  // ownership state
  logic [BN-1:0] w_bmp_q, w_bmp_d, lat_bmp_q, lat_bmp_d, held_d;
  logic [BN-1:0] r_bmp_q [RN];
  logic [BN-1:0] r_bmp_d [RN];
  logic          free_found;

  // arbitration results
  logic [BN-1:0]    ram_en_d;
  logic [BR_AW-1:0] ram_addr_d [BN];
  logic [RN-1:0]    r_vld_d, r_conf_d;

  // pipeline registers
  logic [BN-1:0]    ram_en_p1_q;
  logic [BR_AW-1:0] ram_addr_p1_q [BN];
  logic [RN-1:0]    r_vld_p1_q, r_vld_p2_q, r_conflict_q, r_rvalid_q;
  logic [BN-1:0]    r_sel_p1_q [RN];
  logic [BN-1:0]    r_sel_p2_q [RN];
  logic             w_vld_p1_q, w_vld_p2_q, w_rvalid_q;
  logic [BN-1:0]    w_sel_p1_q, w_sel_p2_q;
  logic [BR_DW-1:0] mem_q [BN][DEPTH];
  logic [BR_DW-1:0] ram_dout_p2_q [BN];
  logic [BR_DW-1:0] r_mux_d [RN];
  logic [BR_DW-1:0] r_data_q [RN];
  logic [BR_DW-1:0] w_mux_d, w_rdata_q;

  // rotation: latest-completed first, then readers, then lowest free buffer for the writer
  always_comb begin
    lat_bmp_d  = lat_bmp_q;
    w_bmp_d    = w_bmp_q;
    free_found = 1'b0;
    if (w_sof && (w_bmp_q != '0)) lat_bmp_d = w_bmp_q;
    held_d = lat_bmp_d;
    for (int k = 0; k < RN; k++) begin
      r_bmp_d[k] = r_sof[k] ? lat_bmp_d : r_bmp_q[k];
      held_d     = held_d | r_bmp_d[k];
    end
    if (w_sof) begin
      w_bmp_d = '0;
      for (int b = BN - 1; b >= 0; b--) begin
        if (!held_d[b]) begin
          w_bmp_d    = '0;
          w_bmp_d[b] = 1'b1;
          free_found = 1'b1;
        end
      end
    end
  end

  // ownership registers; reset drops every ownership immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_bmp_q   <= '0;
      lat_bmp_q <= '0;
      for (int k = 0; k < RN; k++) r_bmp_q[k] <= '0;
    end else begin
      w_bmp_q   <= w_bmp_d;
      lat_bmp_q <= lat_bmp_d;
      for (int k = 0; k < RN; k++) r_bmp_q[k] <= r_bmp_d[k];
    end
  end

  // per-RAM arbitration: writer read-back first (never shares with readers), then lowest reader index
  always_comb begin
    ram_en_d = '0;
    r_vld_d  = '0;
    r_conf_d = '0;
    for (int b = 0; b < BN; b++) begin
      ram_addr_d[b] = w_raddr;
      if (w_ren && w_bmp_q[b]) ram_en_d[b] = 1'b1;
    end
    for (int k = 0; k < RN; k++) begin
      if (r_en[k]) begin
        r_vld_d[k] = 1'b1;
        for (int b = 0; b < BN; b++) begin
          if (r_bmp_q[k][b]) begin
            if (ram_en_d[b]) begin
              r_vld_d[k]  = 1'b0;
              r_conf_d[k] = 1'b1;
            end else begin
              ram_en_d[b]   = 1'b1;
              ram_addr_d[b] = r_addr[k*BR_AW +: BR_AW];
            end
          end
        end
      end
    end
  end

  // ---- stage p1: registered RAM enables/addresses, buffer selects sampled at request time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_en_p1_q  <= '0;
      r_vld_p1_q   <= '0;
      w_vld_p1_q   <= 1'b0;
      r_conflict_q <= '0;
    end else begin
      ram_en_p1_q  <= ram_en_d;
      r_vld_p1_q   <= r_vld_d;
      w_vld_p1_q   <= w_ren;
      r_conflict_q <= r_conf_d;
    end
  end

  // stage p1 data path: addresses and selects carry no reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < BN; b++) ram_addr_p1_q[b] <= ram_addr_d[b];
    for (int k = 0; k < RN; k++) r_sel_p1_q[k] <= r_bmp_q[k];
    w_sel_p1_q <= w_bmp_q;
  end

  // ---- stage p2: block RAM write port and registered read port (read-before-write)
  always_ff @(posedge clk) begin
    for (int b = 0; b < BN; b++) begin
      if (w_en && w_bmp_q[b]) mem_q[b][w_addr] <= w_data;
      if (ram_en_p1_q[b]) ram_dout_p2_q[b] <= mem_q[b][ram_addr_p1_q[b]];
    end
    for (int k = 0; k < RN; k++) r_sel_p2_q[k] <= r_sel_p1_q[k];
    w_sel_p2_q <= w_sel_p1_q;
  end

  // stage p2 valids
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p2_q <= '0;
      w_vld_p2_q <= 1'b0;
    end else begin
      r_vld_p2_q <= r_vld_p1_q;
      w_vld_p2_q <= w_vld_p1_q;
    end
  end

  // one-hot to data mux; an empty select yields zero
  always_comb begin
    w_mux_d = '0;
    for (int k = 0; k < RN; k++) r_mux_d[k] = '0;
    for (int b = 0; b < BN; b++) begin
      if (w_sel_p2_q[b]) w_mux_d = w_mux_d | ram_dout_p2_q[b];
      for (int k = 0; k < RN; k++)
        if (r_sel_p2_q[k][b]) r_mux_d[k] = r_mux_d[k] | ram_dout_p2_q[b];
    end
  end

  // ---- stage p3: output registers hold their value while the valid is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rvalid_q <= '0;
      w_rvalid_q <= 1'b0;
      w_rdata_q  <= '0;
      for (int k = 0; k < RN; k++) r_data_q[k] <= '0;
    end else begin
      r_rvalid_q <= r_vld_p2_q;
      w_rvalid_q <= w_vld_p2_q;
      if (w_vld_p2_q) w_rdata_q <= w_mux_d;
      for (int k = 0; k < RN; k++)
        if (r_vld_p2_q[k]) r_data_q[k] <= r_mux_d[k];
    end
  end

`ifdef MUTEX_BANK_CONFLICT_STAT_EN
  logic [15:0] drops_d, cnt_q;
  logic [16:0] cnt_sum_d;
  assign drops_d   = 16'($countones(r_conf_d));
  assign cnt_sum_d = {1'b0, cnt_q} + {1'b0, drops_d};

  // saturating drop counter, restarted with the current drops on each writer frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        cnt_q <= '0;
    else if (w_sof)     cnt_q <= drops_d;
    else if (cnt_sum_d[16]) cnt_q <= 16'hFFFF;
    else                cnt_q <= cnt_sum_d[15:0];
  end
  assign conflict_cnt = cnt_q;
`endif

  assign w_bmp      = w_bmp_q;
  assign w_rdata    = w_rdata_q;
  assign w_rvalid   = w_rvalid_q;
  assign r_rvalid   = r_rvalid_q;
  assign r_conflict = r_conflict_q;
  for (genvar k = 0; k < RN; k++) begin : g_flat
    assign r_bmp[k*BN +: BN]       = r_bmp_q[k];
    assign r_data[k*BR_DW +: BR_DW] = r_data_q[k];
  end

  a_free_buffer : assert property (@(posedge clk) disable iff (!resetn) w_sof |-> free_found);

endmodule

// File: tb/tb_mutex_bram_bank.sv
// Randomised bench for mutex_bram_bank against a frame-level ownership and
// read-latency model.
module tb_mutex_bram_bank;
  localparam int BN = 4, RN = 2, AW = 12, DW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic w_sof, w_en, w_ren, w_rvalid;
  logic [BN-1:0] w_bmp;
  logic [AW-1:0] w_addr, w_raddr;
  logic [DW-1:0] w_data, w_rdata;
  logic [RN-1:0] r_sof, r_en, r_rvalid, r_conflict;
  logic [BN*RN-1:0] r_bmp;
  logic [AW*RN-1:0] r_addr;
  logic [DW*RN-1:0] r_data;
`ifdef MUTEX_BANK_CONFLICT_STAT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  mutex_bram_bank #(.C_BUFF_NUM(BN), .C_RD_NUM(RN), .BR_AW(AW), .BR_DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .w_sof(w_sof), .w_bmp(w_bmp), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_ren(w_ren), .w_raddr(w_raddr), .w_rdata(w_rdata), .w_rvalid(w_rvalid),
    .r_sof(r_sof), .r_bmp(r_bmp), .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .r_rvalid(r_rvalid), .r_conflict(r_conflict)
`ifdef MUTEX_BANK_CONFLICT_STAT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  typedef struct { logic vld; logic known; logic [DW-1:0] data; logic conf; } rd_t;

  // reference model: buffer indices (-1 = none), memory image, 3-deep read pipes
  int          m_wb, m_lb;
  int          m_rb [RN];
  logic [DW-1:0] m_mem [BN][16];
  logic        m_known [BN][16];
  rd_t         m_rp [3][RN];
  rd_t         m_wp [3];
  logic [DW-1:0] m_rdata [RN];
  logic        m_rknown [RN];
  logic [DW-1:0] m_wdata;
  logic        m_wknown;
  int checks = 0, failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BN-1:0] oh(input int i);
    logic [BN-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_wb = -1; m_lb = -1;
    m_wdata = '0; m_wknown = 1'b1;
    for (int k = 0; k < RN; k++) begin
      m_rb[k] = -1; m_rdata[k] = '0; m_rknown[k] = 1'b1;
    end
    for (int s = 0; s < 3; s++) begin
      m_wp[s] = '{1'b0, 1'b1, '0, 1'b0};
      for (int k = 0; k < RN; k++) m_rp[s][k] = '{1'b0, 1'b1, '0, 1'b0};
    end
  endtask

  // apply one clock edge to the model using the currently driven inputs
  task automatic model_edge();
    rd_t nr [RN];
    rd_t nw;
    int nl, pick, b, a;
    logic lost;
    if (w_en && m_wb >= 0) begin
      m_mem[m_wb][w_addr[3:0]] = w_data;
      m_known[m_wb][w_addr[3:0]] = 1'b1;
    end
    nw = '{w_ren, 1'b1, '0, 1'b0};
    if (w_ren && m_wb >= 0) begin
      nw.data = m_mem[m_wb][w_raddr[3:0]];
      nw.known = m_known[m_wb][w_raddr[3:0]];
    end
    for (int k = 0; k < RN; k++) begin
      nr[k] = '{1'b0, 1'b1, '0, 1'b0};
      if (r_en[k]) begin
        b = m_rb[k];
        a = int'(r_addr[k*AW +: 4]);
        lost = 1'b0;
        for (int j = 0; j < k; j++) if (r_en[j] && b >= 0 && m_rb[j] == b) lost = 1'b1;
        if (lost) nr[k].conf = 1'b1;
        else begin
          nr[k].vld = 1'b1;
          if (b >= 0) begin nr[k].data = m_mem[b][a]; nr[k].known = m_known[b][a]; end
        end
      end
    end
    m_wp[2] = m_wp[1]; m_wp[1] = m_wp[0]; m_wp[0] = nw;
    for (int k = 0; k < RN; k++) begin
      m_rp[2][k] = m_rp[1][k]; m_rp[1][k] = m_rp[0][k]; m_rp[0][k] = nr[k];
      if (m_rp[2][k].vld) begin m_rdata[k] = m_rp[2][k].data; m_rknown[k] = m_rp[2][k].known; end
    end
    if (m_wp[2].vld) begin m_wdata = m_wp[2].data; m_wknown = m_wp[2].known; end
    nl = (w_sof && m_wb >= 0) ? m_wb : m_lb;
    for (int k = 0; k < RN; k++) if (r_sof[k]) m_rb[k] = nl;
    if (w_sof) begin
      pick = -1;
      for (int i = BN - 1; i >= 0; i--) begin
        lost = (i == nl);
        for (int k = 0; k < RN; k++) if (m_rb[k] == i) lost = 1'b1;
        if (!lost) pick = i;
      end
      m_wb = pick;
    end
    m_lb = nl;
  endtask

  task automatic compare_all();
    logic [BN-1:0] rall;
    rall = '0;
    check_val("w_bmp", w_bmp, oh(m_wb));
    check_val("w_rvalid", w_rvalid, m_wp[2].vld);
    if (m_wknown) check_val("w_rdata", w_rdata, m_wdata);
    for (int k = 0; k < RN; k++) begin
      check_val($sformatf("r_bmp%0d", k), r_bmp[k*BN +: BN], oh(m_rb[k]));
      check_val($sformatf("r_rvalid%0d", k), r_rvalid[k], m_rp[2][k].vld);
      check_val($sformatf("r_conflict%0d", k), r_conflict[k], m_rp[0][k].conf);
      if (m_rknown[k]) check_val($sformatf("r_data%0d", k), r_data[k*DW +: DW], m_rdata[k]);
      rall = rall | r_bmp[k*BN +: BN];
    end
    check_val("exclusive", w_bmp & rall, '0);
  endtask

  task automatic idle();
    w_sof = 0; w_en = 0; w_ren = 0; r_sof = '0; r_en = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_raddr(input int k, input int a);
    r_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    for (int b = 0; b < BN; b++) for (int a = 0; a < 16; a++) begin
      m_known[b][a] = 1'b0; m_mem[b][a] = '0;
    end
    idle();
    w_addr = '0; w_raddr = '0; w_data = '0; r_addr = '0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    resetn = 1'b1;
    tick();

    // read before any completed frame: valid with zero data
    r_en = 2'b01; set_raddr(0, 5); tick(); idle(); tick(); tick();
    check_val("null_rvalid", r_rvalid[0], 1'b1);
    check_val("null_rdata", r_data[DW-1:0], 32'h0);

    // first frame, write, second frame, reader picks up the first
    w_sof = 1; tick(); idle();
    check_val("w_bmp_first", w_bmp, 4'b0001);
    w_en = 1; w_addr = 5; w_data = 32'hA5A5A5A5; tick(); idle();
    w_sof = 1; tick(); idle();
    check_val("w_bmp_second", w_bmp, 4'b0010);
    r_sof = 2'b01; tick(); idle();
    check_val("r_bmp0_first", r_bmp[BN-1:0], 4'b0001);
    r_en = 2'b01; set_raddr(0, 5); tick(); idle(); tick();
    check_val("rvalid_t2", r_rvalid[0], 1'b0);
    tick();
    check_val("rvalid_t3", r_rvalid[0], 1'b1);
    check_val("rdata_t3", r_data[DW-1:0], 32'hA5A5A5A5);
    w_en = 1; w_addr = 7; w_data = 32'h12345678; tick(); idle();

    // writer and reader 1 rotate in the same cycle
    w_sof = 1; r_sof = 2'b10; tick(); idle();
    check_val("r_bmp1_same", r_bmp[2*BN-1:BN], 4'b0010);
    check_val("w_bmp_same", w_bmp, 4'b0100);

    // both readers on one buffer, same-cycle requests
    r_sof = 2'b01; tick(); idle();
    r_en = 2'b11; set_raddr(0, 7); set_raddr(1, 5); tick(); idle();
    check_val("conflict_pulse", r_conflict, 2'b10);
    tick(); tick();
    check_val("arb_rvalid", r_rvalid, 2'b01);
    check_val("arb_rdata", r_data[DW-1:0], 32'h12345678);

    // readers on fixed distinct buffers, writer ping-pongs between the other two
    w_sof = 1; tick(); idle();
    r_sof = 2'b10; tick(); idle();
    for (int i = 0; i < 20; i++) begin
      w_sof = 1; w_en = 1; w_addr = AW'($urandom_range(0, 15)); w_data = $urandom;
      tick();
      check_val("pingpong", w_bmp, (i % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    idle();

    // randomised traffic
    for (int c = 0; c < 600; c++) begin
      w_sof = ($urandom_range(0, 7) == 0);
      w_en = $urandom_range(0, 1); w_addr = AW'($urandom_range(0, 15)); w_data = $urandom;
      w_ren = ($urandom_range(0, 2) == 0); w_raddr = AW'($urandom_range(0, 15));
      for (int k = 0; k < RN; k++) begin
        r_sof[k] = ($urandom_range(0, 9) == 0);
        r_en[k] = $urandom_range(0, 1);
        set_raddr(k, $urandom_range(0, 15));
      end
      tick();
    end

    // reset in the middle of a read burst
    idle();
    r_en = 2'b11; w_ren = 1; tick(); tick();
    #3 resetn = 1'b0;
    #1;
    model_reset();
    check_val("rst_w_bmp", w_bmp, '0);
    check_val("rst_r_bmp", r_bmp, '0);
    check_val("rst_rvalid", r_rvalid, '0);
    check_val("rst_wrvalid", w_rvalid, 1'b0);
    check_val("rst_rdata", r_data, '0);
    compare_all();
`ifdef MUTEX_BANK_CONFLICT_STAT_EN
    check_val("rst_conflict_cnt", conflict_cnt, 16'h0);
`endif
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();
    r_en = 2'b01; set_raddr(0, 5); tick(); idle(); tick(); tick();
    check_val("post_rst_rvalid", r_rvalid[0], 1'b1);
    check_val("post_rst_rdata", r_data[DW-1:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
